tick_bcd_counter: RTL and testbench

- Consumes the square-wave output of the selectable-rate clock divider, which toggles between the 1 s and 0.1 s rates.
- Treats each rising edge of that wave as one count tick.
- Maintains a two-digit BCD up/down counter, modulo MAX+1, and drives a time-multiplexed two-digit common-anode seven-segment display.
- Sits between the divider and the board's display pins.

---
 rtl/tick_bcd_counter_pkg.sv | 27 ++
 rtl/seg7_decode.sv | 27 ++
 rtl/tick_bcd_counter.sv | 127 ++++++++++++
 tb/tb_tick_bcd_counter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/tick_bcd_counter_pkg.sv
// Shared constants for the tick counter and its seven-segment display path.
// Segment codes are active-low, ordered {g,f,e,d,c,b,a}.
package tick_bcd_counter_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Digit enables are active-low: [0]=units, [1]=tens.
    localparam logic [1:0] DIG_UNITS = 2'b10;
    localparam logic [1:0] DIG_TENS  = 2'b01;
    localparam logic [1:0] DIG_OFF   = 2'b11;

    typedef enum logic {
        IDX_UNITS = 1'b0,
        IDX_TENS  = 1'b1
    } dig_idx_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low seven-segment decoder.
// Codes above 9 decode to blank.
module seg7_decode
    import tick_bcd_counter_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_BLANK;
        case (bcd)
            4'd0:    seg_n = SEG_0;
            4'd1:    seg_n = SEG_1;
            4'd2:    seg_n = SEG_2;
            4'd3:    seg_n = SEG_3;
            4'd4:    seg_n = SEG_4;
            4'd5:    seg_n = SEG_5;
            4'd6:    seg_n = SEG_6;
            4'd7:    seg_n = SEG_7;
            4'd8:    seg_n = SEG_8;
            4'd9:    seg_n = SEG_9;
            default: seg_n = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/tick_bcd_counter.sv
// Two-digit BCD up/down counter advanced by rising edges of an asynchronous
// tick input, driving a multiplexed two-digit common-anode display.
module tick_bcd_counter
    import tick_bcd_counter_pkg::*;
#(
    parameter int unsigned MAX      = 59,
    parameter int unsigned SCAN_DIV = 50_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       run,
    input  logic       up_dn,
    input  logic       clr,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       wrap,
    output logic [6:0] seg,
    output logic [1:0] dig_sel
);

    localparam logic [3:0]         MAX_T     = 4'(MAX / 10);
    localparam logic [3:0]         MAX_U     = 4'(MAX % 10);
    localparam int unsigned        SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0]  SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    logic              s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic              tick_p;
    logic [3:0]        tens_q, tens_d, units_q, units_d;
    logic              wrap_q, wrap_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    dig_idx_e          dig_idx_q, dig_idx_d;
    logic [6:0]        seg_q, seg_d;
    logic [1:0]        dig_sel_q, dig_sel_d;
    logic [3:0]        cur_digit;
    logic [6:0]        cur_seg;

    assign tick_p    = s2_q & ~s3_q;
    assign cur_digit = (dig_idx_q == IDX_TENS) ? tens_q : units_q;

    seg7_decode u_dec (
        .bcd   (cur_digit),
        .seg_n (cur_seg)
    );

    always_comb begin
        s1_d       = tick_in;
        s2_d       = s1_q;
        s3_d       = s2_q;
        tens_d     = tens_q;
        units_d    = units_q;
        wrap_d     = 1'b0;
        scan_cnt_d = scan_cnt_q + 1'b1;
        dig_idx_d  = dig_idx_q;

        if (clr) begin
            tens_d  = '0;
            units_d = '0;
        end else if (tick_p && run) begin
            if (up_dn) begin
                if (tens_q == MAX_T && units_q == MAX_U) begin
                    tens_d  = '0;
                    units_d = '0;
                    wrap_d  = 1'b1;
                end else if (units_q == 4'd9) begin
                    units_d = '0;
                    tens_d  = tens_q + 4'd1;
                end else begin
                    units_d = units_q + 4'd1;
                end
            end else begin
                if (tens_q == 4'd0 && units_q == 4'd0) begin
                    tens_d  = MAX_T;
                    units_d = MAX_U;
                    wrap_d  = 1'b1;
                end else if (units_q == 4'd0) begin
                    units_d = 4'd9;
                    tens_d  = tens_q - 4'd1;
                end else begin
                    units_d = units_q - 4'd1;
                end
            end
        end

        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            dig_idx_d  = (dig_idx_q == IDX_UNITS) ? IDX_TENS : IDX_UNITS;
        end

        // Display registers follow the current index/count, one cycle behind.
        seg_d     = cur_seg;
        dig_sel_d = (dig_idx_q == IDX_TENS) ? DIG_TENS : DIG_UNITS;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            tens_q     <= '0;
            units_q    <= '0;
            wrap_q     <= 1'b0;
            scan_cnt_q <= '0;
            dig_idx_q  <= IDX_UNITS;
            seg_q      <= SEG_BLANK;
            dig_sel_q  <= DIG_OFF;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
            tens_q     <= tens_d;
            units_q    <= units_d;
            wrap_q     <= wrap_d;
            scan_cnt_q <= scan_cnt_d;
            dig_idx_q  <= dig_idx_d;
            seg_q      <= seg_d;
            dig_sel_q  <= dig_sel_d;
        end
    end

    assign tens    = tens_q;
    assign units   = units_q;
    assign wrap    = wrap_q;
    assign seg     = seg_q;
    assign dig_sel = dig_sel_q;

endmodule

// File: tb/tb_tick_bcd_counter.sv
// Directed bench for tick_bcd_counter with MAX=59 and a short scan period.
module tb_tick_bcd_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_in = 1'b0;
    logic       run = 1'b0;
    logic       up_dn = 1'b1;
    logic       clr = 1'b0;
    logic [3:0] tens, units;
    logic       wrap;
    logic [6:0] seg;
    logic [1:0] dig_sel;

    int checks = 0;
    int failures = 0;
    int wrap_seen = 0;

    typedef struct {
        logic       run;
        logic       up_dn;
        int         pulses;
        int         hi;
        logic [3:0] exp_tens;
        logic [3:0] exp_units;
        int         exp_wraps;
    } vec_t;

    vec_t vecs[9];

    tick_bcd_counter #(.MAX(59), .SCAN_DIV(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .tick_in (tick_in),
        .run     (run),
        .up_dn   (up_dn),
        .clr     (clr),
        .tens    (tens),
        .units   (units),
        .wrap    (wrap),
        .seg     (seg),
        .dig_sel (dig_sel)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (wrap === 1'b1) wrap_seen++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse(input int hi, input int lo);
        tick_in = 1'b1;
        repeat (hi) @(negedge clk);
        tick_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int w0, run_len, expv;
        logic [1:0] prev_sel;
        bit seen_change;

        vecs[0] = '{1'b1, 1'b0,  1,   5, 4'd5, 4'd9, 1};
        vecs[1] = '{1'b1, 1'b0,  1,   5, 4'd5, 4'd8, 0};
        vecs[2] = '{1'b0, 1'b1,  3,   5, 4'd5, 4'd8, 0};
        vecs[3] = '{1'b1, 1'b1,  1,   1, 4'd5, 4'd9, 0};
        vecs[4] = '{1'b1, 1'b1,  1, 100, 4'd0, 4'd0, 1};
        vecs[5] = '{1'b1, 1'b0,  1,   1, 4'd5, 4'd9, 1};
        vecs[6] = '{1'b1, 1'b1, 10,   5, 4'd0, 4'd9, 1};
        vecs[7] = '{1'b1, 1'b0,  9,   5, 4'd0, 4'd0, 0};
        vecs[8] = '{1'b1, 1'b1, 37,   5, 4'd3, 4'd7, 0};

        // Reset state
        repeat (3) begin
            @(negedge clk);
            check("rst_count", {tens, units}, 8'h00);
            check("rst_wrap", wrap, 0);
            check("rst_seg", seg, 7'h7F);
            check("rst_dig_sel", dig_sel, 2'b11);
        end
        rst = 1'b0;
        @(negedge clk);
        check("first_seg", seg, 7'h40);
        check("first_dig_sel", dig_sel, 2'b10);

        // Up count 00..59 then wrap to 00
        run = 1'b1;
        up_dn = 1'b1;
        w0 = wrap_seen;
        for (int i = 0; i < 60; i++) begin
            if (i == 59) begin
                tick_in = 1'b1;
                @(negedge clk);
                check("wrap_k", wrap, 0);
                @(negedge clk);
                check("wrap_k1", wrap, 0);
                check("pre_wrap_count", {tens, units}, 8'h59);
                @(negedge clk);
                check("wrap_k2", wrap, 1);
                check("wrap_count", {tens, units}, 8'h00);
                @(negedge clk);
                check("wrap_k3", wrap, 0);
                @(negedge clk);
                tick_in = 1'b0;
                repeat (5) @(negedge clk);
            end else begin
                pulse(5, 5);
                expv = i + 1;
                check("up_count", {tens, units}, {4'(expv / 10), 4'(expv % 10)});
            end
        end
        check("up_wrap_total", wrap_seen - w0, 1);

        // Table: borrow, hold, glitch, long level, mixed directions
        foreach (vecs[v]) begin
            run = vecs[v].run;
            up_dn = vecs[v].up_dn;
            w0 = wrap_seen;
            for (int p = 0; p < vecs[v].pulses; p++) pulse(vecs[v].hi, 5);
            check("vec_count", {tens, units}, {vecs[v].exp_tens, vecs[v].exp_units});
            check("vec_wraps", wrap_seen - w0, vecs[v].exp_wraps);
        end

        // clr coincident with tick_p at 37
        run = 1'b1;
        up_dn = 1'b1;
        w0 = wrap_seen;
        tick_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_count", {tens, units}, 8'h00);
        check("clr_wrap", wrap, 0);
        @(negedge clk);
        tick_in = 1'b0;
        repeat (5) @(negedge clk);
        check("clr_tick_lost", {tens, units}, 8'h00);
        check("clr_no_wrap", wrap_seen - w0, 0);

        // Display scan at 42
        for (int p = 0; p < 42; p++) pulse(5, 5);
        check("scan_count", {tens, units}, 8'h42);
        prev_sel = dig_sel;
        run_len = 0;
        seen_change = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (dig_sel != prev_sel) begin
                if (seen_change) check("slot_len", run_len, 4);
                seen_change = 1;
                run_len = 1;
                prev_sel = dig_sel;
            end else begin
                run_len++;
            end
            if (dig_sel == 2'b01) check("seg_tens", seg, 7'h19);
            else if (dig_sel == 2'b10) check("seg_units", seg, 7'h24);
            else check("dig_sel_valid", dig_sel, 2'b10);
        end

        // Async reset mid-slot
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_seg", seg, 7'h7F);
        check("arst_dig_sel", dig_sel, 2'b11);
        check("arst_count", {tens, units}, 8'h00);
        check("arst_wrap", wrap, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("arst_release_seg", seg, 7'h40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
